priority_ack_decoder: RTL and testbench
=======================================

Name: priority_ack_decoder

Overview:
- Receiving end of the 8-to-3 active-low priority encoder.
- Takes the encoder's code/GS/EO outputs and latches the encoded request.
- Drives a one-hot, active-low acknowledge strobe back to the requesting line (74138-style decode) for a programmable pulse width, then waits for the request to drop.
- Sits between the encoder and the request sources; it closes the request/acknowledge loop.

Parameters:
- PULSE_W, 4, acknowledge strobe width in clock cycles (legal 1..255).
- GAP_W, 1, minimum idle cycles after release before the next request is accepted (legal 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_n  input  1  active-low block enable.
- code  input  3  encoder code; 000 = line 7 (highest), 111 = line 0.
- gs  input  1  encoder group select; active-low, 0 = a request is present.
- eo  input  1  encoder enable-out; 0 = enabled and no line requesting.
- ack_n  output  8  active-low one-hot acknowledge; bit index = ~code_q.
- busy  output  1  high in any state except IDLE.
- code_q  output  3  latched code of the request currently being serviced.
- no_req  output  1  registered copy of ~eo; high one cycle after the encoder reports an empty request set.
- ack_cnt  output  8  number of acknowledges issued; wraps 255 -> 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ack_n=8'hFF, busy=0, code_q=3'b111, no_req=0, ack_cnt=0, internal counter=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, PULSE, HOLD, GAP.
- IDLE:
  - If en_n=0 and gs=0: latch code into code_q; go to PULSE next edge.
  - On that same edge ack_n[~code] goes low, counter loads PULSE_W-1, and ack_cnt increments.
  - So the ack is visible 1 cycle after gs is sampled low.
- PULSE:
  - ack_n holds a single 0 at bit ~code_q for exactly PULSE_W cycles.
  - When counter=0: ack_n returns to 8'hFF and the state goes to HOLD.
  - Changes on code or gs during PULSE are ignored; code_q stays frozen.
- HOLD:
  - Waits for release, defined as gs=1 or code != code_q (a different line now wins).
  - On release: go to GAP and load counter with GAP_W-1.
  - ack_n stays 8'hFF throughout HOLD.
- GAP:
  - Counts down; at 0 returns to IDLE.
  - No request is sampled during GAP. A request already present on the IDLE cycle after GAP is accepted on that cycle.
- en_n=1 in any state:
  - Next edge forces state=IDLE, ack_n=8'hFF, counter=0.
  - code_q and ack_cnt are retained.
  - An aborted pulse is still counted, because it was counted at issue.
- Encoder disabled (gs=1, eo=1): treated as no request; no_req=0.
- No-request case (gs=1, eo=0): no_req=1; no other effect.
- Invalid input (gs=0 and eo=0): treated as a request (gs has priority).
- ack_cnt: increments only on the IDLE->PULSE transition; 8-bit modulo-256 wrap.
- busy: registered; equals (next state != IDLE).
- Invariant: ack_n never has more than one 0 bit in any cycle.
- Counter width: 8 bits, loaded as PARAM-1, so PULSE_W=1 gives a single-cycle ack.
- Reset asserted mid-PULSE: ack_n goes to 8'hFF immediately (asynchronously).

Test Plan:
- Reset, en_n=0, gs=0, code=3'b000 -> one cycle later ack_n=8'h7F for 4 cycles, then 8'hFF; ack_cnt=1, code_q=000, busy=1 until release.
- Hold gs=0, code=101 after the pulse -> stays in HOLD with ack_n=8'hFF and no second ack; set gs=1 -> GAP for 1 cycle, IDLE, busy=0.
- In HOLD, change code 101->010 with gs=0 -> release, GAP, then a new ack at ack_n=8'hDF (bit 5); ack_cnt increments by 1.
- Assert en_n=1 on the 2nd PULSE cycle -> next edge ack_n=8'hFF, busy=0; ack_cnt unchanged from the issued value.
- gs=1, eo=0 -> no_req=1 one cycle later; ack_n=8'hFF, no state change. Separately: assert rst mid-pulse -> ack_n=8'hFF without waiting for a clock edge, and all outputs at reset values.
- 256 request/release cycles with PULSE_W=1, GAP_W=1 -> ack_cnt wraps to 0; every ack is exactly 1 cycle wide and one-hot.

Source files
------------

// File: rtl/priority_ack_decoder.sv
// Closes the 8-to-3 priority encoder loop: latches the winning code and returns a one-hot
// active-low ack strobe one cycle after the request is sampled; no backpressure, en_n aborts to IDLE.
module priority_ack_decoder #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_n,
    input  logic [2:0] code,
    input  logic       gs,
    input  logic       eo,
    output logic [7:0] ack_n,
    output logic       busy,
    output logic [2:0] code_q,
    output logic       no_req,
    output logic [7:0] ack_cnt
);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD, GAP} state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_W - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ack_n_q, ack_n_d;
    logic       busy_q, busy_d;
    logic [2:0] code_d;
    logic       no_req_q, no_req_d;
    logic [7:0] ack_cnt_q, ack_cnt_d;
    logic       accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ack_n_q   <= 8'hFF;
            busy_q    <= 1'b0;
            code_q    <= 3'b111;
            no_req_q  <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_n_q   <= ack_n_d;
            busy_q    <= busy_d;
            code_q    <= code_d;
            no_req_q  <= no_req_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!gs) begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LD;
                    end
                end
                PULSE: begin
                    if (cnt_q == 8'd0) state_d = HOLD;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                // A different winning line also counts as release of the serviced one.
                HOLD: begin
                    if (gs || (code != code_q)) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end
                end
                GAP: begin
                    if (cnt_q == 8'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        accept    = (state_q == IDLE) && !en_n && !gs;
        code_d    = accept ? code : code_q;
        ack_cnt_d = accept ? ack_cnt_q + 8'd1 : ack_cnt_q;
        busy_d    = (state_d != IDLE);
        no_req_d  = ~eo;
        if (accept)                  ack_n_d = ~(8'd1 << ~code);
        else if (state_d == PULSE)   ack_n_d = ack_n_q;
        else                         ack_n_d = 8'hFF;
    end

    assign ack_n   = ack_n_q;
    assign busy    = busy_q;
    assign no_req  = no_req_q;
    assign ack_cnt = ack_cnt_q;

endmodule

// File: tb/tb_priority_ack_decoder.sv
// Bench for priority_ack_decoder: two instances (PULSE_W=4/GAP_W=1 and PULSE_W=1/GAP_W=1) on shared inputs.
module tb_priority_ack_decoder;

    localparam int PW0 = 4, GW0 = 1, PW1 = 1, GW1 = 1;
    localparam int PH_IDLE = 0, PH_PULSE = 1, PH_HOLD = 2, PH_GAP = 3;

    logic       clk, rst, en_n, gs, eo;
    logic [2:0] code;
    logic [7:0] ack_n0, ack_n1, ack_cnt0, ack_cnt1;
    logic       busy0, busy1, no_req0, no_req1;
    logic [2:0] code_q0, code_q1;

    priority_ack_decoder #(.PULSE_W(PW0), .GAP_W(GW0)) u0 (
        .clk(clk), .rst(rst), .en_n(en_n), .code(code), .gs(gs), .eo(eo),
        .ack_n(ack_n0), .busy(busy0), .code_q(code_q0), .no_req(no_req0), .ack_cnt(ack_cnt0));
    priority_ack_decoder #(.PULSE_W(PW1), .GAP_W(GW1)) u1 (
        .clk(clk), .rst(rst), .en_n(en_n), .code(code), .gs(gs), .eo(eo),
        .ack_n(ack_n1), .busy(busy1), .code_q(code_q1), .no_req(no_req1), .ack_cnt(ack_cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses1  = 0;

    // Reference: phase plus cycles remaining in that phase
    int m_ph[2], m_left[2], m_cq[2], m_cnt[2], m_nr[2];
    int pw_tab[2] = '{PW0, PW1};
    int gw_tab[2] = '{GW0, GW1};

    typedef struct {
        logic       en_n;
        logic [2:0] code;
        logic       gs;
        logic       eo;
        logic [7:0] ack_n;
        logic       busy;
        logic [2:0] code_q;
        logic       no_req;
        logic [7:0] ack_cnt;
    } vec_t;
    vec_t vt[22];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h, want 0x%0h at %0t", d, nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = PH_IDLE; m_left[d] = 0; m_cq[d] = 7; m_cnt[d] = 0; m_nr[d] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            m_nr[d] = eo ? 0 : 1;
            if (en_n) begin
                m_ph[d] = PH_IDLE; m_left[d] = 0;
            end else if (m_ph[d] == PH_IDLE) begin
                if (!gs) begin
                    m_ph[d] = PH_PULSE; m_left[d] = pw_tab[d];
                    m_cq[d] = int'(code); m_cnt[d] = (m_cnt[d] + 1) % 256;
                end
            end else if (m_ph[d] == PH_PULSE) begin
                m_left[d]--;
                if (m_left[d] == 0) m_ph[d] = PH_HOLD;
            end else if (m_ph[d] == PH_HOLD) begin
                if (gs || int'(code) != m_cq[d]) begin
                    m_ph[d] = PH_GAP; m_left[d] = gw_tab[d];
                end
            end else begin
                m_left[d]--;
                if (m_left[d] == 0) m_ph[d] = PH_IDLE;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [7:0] a, input logic b,
                             input logic [2:0] cq, input logic nr, input logic [7:0] c);
        logic [7:0] exp_ack;
        exp_ack = (m_ph[d] == PH_PULSE) ? (8'hFF ^ 8'(1 << (7 - m_cq[d]))) : 8'hFF;
        chk("model.ack_n", d, 32'(a), 32'(exp_ack));
        chk("model.busy", d, 32'(b), 32'(m_ph[d] != PH_IDLE));
        chk("model.code_q", d, 32'(cq), 32'(m_cq[d]));
        chk("model.no_req", d, 32'(nr), 32'(m_nr[d]));
        chk("model.ack_cnt", d, 32'(c), 32'(m_cnt[d]));
        chk("onehot", d, 32'($countones(~a) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_dut(0, ack_n0, busy0, code_q0, no_req0, ack_cnt0);
        check_dut(1, ack_n1, busy1, code_q1, no_req1, ack_cnt1);
        if (ack_n1 != 8'hFF) pulses1++;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, ".ack_n"}, 0, 32'(ack_n0), 32'hFF);
        chk({nm, ".busy"}, 0, 32'(busy0), 32'd0);
        chk({nm, ".code_q"}, 0, 32'(code_q0), 32'd7);
        chk({nm, ".no_req"}, 0, 32'(no_req0), 32'd0);
        chk({nm, ".ack_cnt"}, 0, 32'(ack_cnt0), 32'd0);
        chk({nm, ".ack_n"}, 1, 32'(ack_n1), 32'hFF);
        chk({nm, ".ack_cnt"}, 1, 32'(ack_cnt1), 32'd0);
    endtask

    task automatic idle_inputs();
        en_n = 1'b0; gs = 1'b1; eo = 1'b1; code = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b0, 3'b000, 1'b0, 1'b1, 8'h7F, 1'b1, 3'b000, 1'b0, 8'd1};
        vt[1]  = '{1'b0, 3'b000, 1'b0, 1'b1, 8'h7F, 1'b1, 3'b000, 1'b0, 8'd1};
        vt[2]  = '{1'b0, 3'b000, 1'b0, 1'b1, 8'h7F, 1'b1, 3'b000, 1'b0, 8'd1};
        vt[3]  = '{1'b0, 3'b000, 1'b0, 1'b1, 8'h7F, 1'b1, 3'b000, 1'b0, 8'd1};
        vt[4]  = '{1'b0, 3'b000, 1'b0, 1'b1, 8'hFF, 1'b1, 3'b000, 1'b0, 8'd1};
        vt[5]  = '{1'b0, 3'b000, 1'b0, 1'b1, 8'hFF, 1'b1, 3'b000, 1'b0, 8'd1};
        vt[6]  = '{1'b0, 3'b000, 1'b1, 1'b1, 8'hFF, 1'b1, 3'b000, 1'b0, 8'd1};
        vt[7]  = '{1'b0, 3'b000, 1'b1, 1'b1, 8'hFF, 1'b0, 3'b000, 1'b0, 8'd1};
        vt[8]  = '{1'b0, 3'b000, 1'b1, 1'b0, 8'hFF, 1'b0, 3'b000, 1'b1, 8'd1};
        vt[9]  = '{1'b0, 3'b000, 1'b1, 1'b1, 8'hFF, 1'b0, 3'b000, 1'b0, 8'd1};
        vt[10] = '{1'b0, 3'b101, 1'b0, 1'b1, 8'hFB, 1'b1, 3'b101, 1'b0, 8'd2};
        vt[11] = '{1'b0, 3'b101, 1'b0, 1'b1, 8'hFB, 1'b1, 3'b101, 1'b0, 8'd2};
        vt[12] = '{1'b0, 3'b101, 1'b0, 1'b1, 8'hFB, 1'b1, 3'b101, 1'b0, 8'd2};
        vt[13] = '{1'b0, 3'b101, 1'b0, 1'b1, 8'hFB, 1'b1, 3'b101, 1'b0, 8'd2};
        vt[14] = '{1'b0, 3'b101, 1'b0, 1'b1, 8'hFF, 1'b1, 3'b101, 1'b0, 8'd2};
        vt[15] = '{1'b0, 3'b101, 1'b0, 1'b1, 8'hFF, 1'b1, 3'b101, 1'b0, 8'd2};
        vt[16] = '{1'b0, 3'b010, 1'b0, 1'b1, 8'hFF, 1'b1, 3'b101, 1'b0, 8'd2};
        vt[17] = '{1'b0, 3'b010, 1'b0, 1'b1, 8'hFF, 1'b0, 3'b101, 1'b0, 8'd2};
        vt[18] = '{1'b0, 3'b010, 1'b0, 1'b0, 8'hDF, 1'b1, 3'b010, 1'b1, 8'd3};
        vt[19] = '{1'b0, 3'b010, 1'b0, 1'b1, 8'hDF, 1'b1, 3'b010, 1'b0, 8'd3};
        vt[20] = '{1'b1, 3'b010, 1'b0, 1'b1, 8'hFF, 1'b0, 3'b010, 1'b0, 8'd3};
        vt[21] = '{1'b1, 3'b010, 1'b0, 1'b1, 8'hFF, 1'b0, 3'b010, 1'b0, 8'd3};

        rst = 1'b1;
        idle_inputs();
        #1;
        check_reset_vals("async_reset");
        do_reset();

        // Directed table against the PULSE_W=4 instance
        for (int i = 0; i < 22; i++) begin
            en_n = vt[i].en_n; code = vt[i].code; gs = vt[i].gs; eo = vt[i].eo;
            tick();
            chk($sformatf("tbl[%0d].ack_n", i), 0, 32'(ack_n0), 32'(vt[i].ack_n));
            chk($sformatf("tbl[%0d].busy", i), 0, 32'(busy0), 32'(vt[i].busy));
            chk($sformatf("tbl[%0d].code_q", i), 0, 32'(code_q0), 32'(vt[i].code_q));
            chk($sformatf("tbl[%0d].no_req", i), 0, 32'(no_req0), 32'(vt[i].no_req));
            chk($sformatf("tbl[%0d].ack_cnt", i), 0, 32'(ack_cnt0), 32'(vt[i].ack_cnt));
        end

        // Reset asserted mid-pulse must clear outputs without a clock edge
        en_n = 1'b0; gs = 1'b0; eo = 1'b1; code = 3'b011;
        tick();
        chk("midpulse.pre_ack_n", 0, 32'(ack_n0), 32'hEF);
        tick();
        rst = 1'b1;
        #2;
        check_reset_vals("midpulse_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        tick();

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            en_n = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) gs = ~gs;
            if ($urandom_range(0, 7) == 0) code = 3'($urandom);
            eo = 1'($urandom);
            tick();
        end

        // 256 request/release rounds: counter wraps, each PULSE_W=1 ack lasts one cycle
        do_reset();
        pulses1 = 0;
        for (int i = 0; i < 256; i++) begin
            en_n = 1'b0; eo = 1'b1; gs = 1'b0; code = 3'($urandom);
            tick();
            tick();
            gs = 1'b1;
            tick();
            tick();
        end
        chk("wrap.ack_cnt", 1, 32'(ack_cnt1), 32'd0);
        chk("wrap.pulse_cycles", 1, 32'(pulses1), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
